timer_intr_ctrl: RTL and testbench

TIMER_INTR_CTRL -- requirements
Module: timer_intr_ctrl

---
 rtl/timer_pkg.sv | 32 +++
 rtl/timer_intr_ctrl_prescaler.sv | 31 +++
 rtl/timer_intr_ctrl.sv | 155 +++++++++++++++
 tb/tb_timer_intr_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the memory-mapped machine timer: register offsets,
// CTRL bit positions, access-size encoding and the run-state enum.
package timer_pkg;

   localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
   localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
   localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
   localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
   localparam logic [2:0] OFF_CTRL        = 3'd4;
   localparam logic [2:0] OFF_PRESCALE    = 3'd5;
   localparam logic [2:0] OFF_STATUS      = 3'd6;
   localparam logic [2:0] OFF_RSVD        = 3'd7;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_PERIODIC = 1;
   localparam int CTRL_IE       = 2;
   localparam int STATUS_PEND   = 0;

   localparam logic [2:0]  MEM_WORD     = 3'b010;
   localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Zero-extends a 3-bit field into a 32-bit read word.
   function automatic logic [31:0] zext3(input logic [2:0] v);
      return {29'd0, v};
   endfunction

endpackage

// File: rtl/timer_intr_ctrl_prescaler.sv
// Prescale counter: while running, counts 0..i_prescale and emits a one-cycle
// tick on the terminal count; i_start restarts the count when the timer is enabled.
module prescaler (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_run,
   input  logic        i_start,
   input  logic [15:0] i_prescale,
   output logic        o_tick
);

   logic [15:0] r_cnt;
   logic        w_term;

   assign w_term = (r_cnt == i_prescale);
   assign o_tick = i_run & w_term;

   // Count register: cleared on start, held while idle, wraps on terminal count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= 16'd0;
      end else if (i_start) begin
         r_cnt <= 16'd0;
      end else if (i_run) begin
         r_cnt <= w_term ? 16'd0 : (r_cnt + 16'd1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

endmodule

// File: rtl/timer_intr_ctrl.sv
// Memory-mapped 64-bit machine timer with compare interrupt, optional
// periodic reload and a 16-bit prescaler; word-only writes, zero-latency reads.
module timer_intr_ctrl
   import timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_2000
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  mem_mode,
   output logic [31:0] out_data,
   output logic        t_intr
);

   state_t      r_state;
   logic [63:0] r_mtime;
   logic [63:0] r_mtimecmp;
   logic [2:0]  r_ctrl;
   logic [15:0] r_prescale;
   logic        r_pend;
   logic        r_t_intr;

   logic        w_hit;
   logic [2:0]  w_off;
   logic        w_wr;
   logic        w_wr_mtlo;
   logic        w_wr_mthi;
   logic        w_wr_cmplo;
   logic        w_wr_cmphi;
   logic        w_wr_ctrl;
   logic        w_wr_presc;
   logic        w_wr_status;
   logic        w_run;
   logic        w_start;
   logic        w_tick;
   logic        w_reload;
   logic        w_pend_set;
   logic        w_pend_clr;
   logic        w_unused;

   assign w_hit    = (addr[31:5] == BASE_ADDR[31:5]);
   assign w_off    = addr[4:2];
   assign w_unused = ^addr[1:0];

   assign w_wr        = wr_en & w_hit & (mem_mode == MEM_WORD);
   assign w_wr_mtlo   = w_wr & (w_off == OFF_MTIME_LO);
   assign w_wr_mthi   = w_wr & (w_off == OFF_MTIME_HI);
   assign w_wr_cmplo  = w_wr & (w_off == OFF_MTIMECMP_LO);
   assign w_wr_cmphi  = w_wr & (w_off == OFF_MTIMECMP_HI);
   assign w_wr_ctrl   = w_wr & (w_off == OFF_CTRL);
   assign w_wr_presc  = w_wr & (w_off == OFF_PRESCALE);
   assign w_wr_status = w_wr & (w_off == OFF_STATUS);

   assign w_run   = (r_state == ST_RUN);
   assign w_start = (r_state == ST_IDLE) & w_wr_ctrl & wdata[CTRL_EN];

   // Reload compares the pre-tick value, so MTIME visits MTIMECMP for a full tick period.
   assign w_reload   = r_ctrl[CTRL_PERIODIC] & (r_mtime == r_mtimecmp);
   assign w_pend_set = w_run & ((r_mtime >= r_mtimecmp) | (w_tick & w_reload));
   assign w_pend_clr = (w_wr_status & wdata[STATUS_PEND]) | w_wr_cmplo | w_wr_cmphi;

   prescaler u_prescaler (
      .clk        (clk),
      .rst        (rst),
      .i_run      (w_run),
      .i_start    (w_start),
      .i_prescale (r_prescale),
      .o_tick     (w_tick)
   );

   // Run-state FSM: follows the EN bit as written by software.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: r_state <= (w_wr_ctrl &  wdata[CTRL_EN]) ? ST_RUN  : ST_IDLE;
            ST_RUN:  r_state <= (w_wr_ctrl & ~wdata[CTRL_EN]) ? ST_IDLE : ST_RUN;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Software-only configuration registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mtimecmp <= MTIMECMP_RST;
         r_ctrl     <= 3'd0;
         r_prescale <= 16'd0;
      end else begin
         if (w_wr_cmplo) r_mtimecmp[31:0]  <= wdata;
         if (w_wr_cmphi) r_mtimecmp[63:32] <= wdata;
         if (w_wr_ctrl)  r_ctrl            <= wdata[2:0];
         if (w_wr_presc) r_prescale        <= wdata[15:0];
      end
   end

   // MTIME: a software write to either half beats the same-cycle tick.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mtime <= 64'd0;
      end else if (w_wr_mtlo) begin
         r_mtime <= {r_mtime[63:32], wdata};
      end else if (w_wr_mthi) begin
         r_mtime <= {wdata, r_mtime[31:0]};
      end else if (w_tick) begin
         r_mtime <= w_reload ? 64'd0 : (r_mtime + 64'd1);
      end else begin
         r_mtime <= r_mtime;
      end
   end

   // Pending flag and registered interrupt; a set in the same cycle beats a clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pend   <= 1'b0;
         r_t_intr <= 1'b0;
      end else begin
         if (w_pend_set) begin
            r_pend <= 1'b1;
         end else if (w_pend_clr) begin
            r_pend <= 1'b0;
         end else begin
            r_pend <= r_pend;
         end
         r_t_intr <= r_pend & r_ctrl[CTRL_IE];
      end
   end

   assign t_intr = r_t_intr;

   // Zero-latency read mux.
   always_comb begin
      out_data = 32'd0;
      if (rd_en & w_hit) begin
         case (w_off)
            OFF_MTIME_LO:    out_data = r_mtime[31:0];
            OFF_MTIME_HI:    out_data = r_mtime[63:32];
            OFF_MTIMECMP_LO: out_data = r_mtimecmp[31:0];
            OFF_MTIMECMP_HI: out_data = r_mtimecmp[63:32];
            OFF_CTRL:        out_data = zext3(r_ctrl);
            OFF_PRESCALE:    out_data = {16'd0, r_prescale};
            OFF_STATUS:      out_data = {31'd0, r_pend};
            default:         out_data = 32'd0;
         endcase
      end else begin
         out_data = 32'd0;
      end
   end

endmodule

// File: tb/tb_timer_intr_ctrl.sv
// Scenario bench for timer_intr_ctrl: expected register values are queued as
// reads are issued, then popped and compared at the end of each scenario.
module tb_timer_intr_ctrl;
   import timer_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_2000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rd_en = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [2:0]  mem_mode = 3'd0;
   logic [31:0] out_data;
   logic        t_intr;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       nm;
      logic [31:0] v;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] got_q[$];

   always #5 clk = ~clk;

   timer_intr_ctrl #(.BASE_ADDR(BASE)) dut (
      .clk      (clk),
      .rst      (rst),
      .rd_en    (rd_en),
      .wr_en    (wr_en),
      .addr     (addr),
      .wdata    (wdata),
      .mem_mode (mem_mode),
      .out_data (out_data),
      .t_intr   (t_intr)
   );

   function automatic logic [31:0] ra(input logic [2:0] off);
      return BASE + {27'd0, off, 2'b00};
   endfunction

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] mode);
      addr = a; wdata = d; mem_mode = mode; wr_en = 1'b1;
      @(posedge clk); #1;
      wr_en = 1'b0; addr = 32'd0; wdata = 32'd0; mem_mode = 3'd0;
   endtask

   task automatic wreg(input logic [2:0] off, input logic [31:0] d);
      wr(ra(off), d, 3'b010);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd_at(input string nm, input logic [31:0] a, input logic rden, input logic [31:0] v);
      exp_t e;
      e.nm = nm; e.v = v;
      exp_q.push_back(e);
      addr = a; rd_en = rden;
      #1;
      got_q.push_back(out_data);
      rd_en = 1'b0; addr = 32'd0;
   endtask

   task automatic rd(input string nm, input logic [2:0] off, input logic [31:0] v);
      rd_at(nm, ra(off), 1'b1, v);
   endtask

   task automatic intr(input string nm, input logic v);
      exp_t e;
      e.nm = nm; e.v = {31'd0, v};
      exp_q.push_back(e);
      got_q.push_back({31'd0, t_intr});
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      exp_t e; logic [31:0] g;
      do_reset();
      rd("rst mtime_lo", OFF_MTIME_LO, 32'd0);
      rd("rst mtime_hi", OFF_MTIME_HI, 32'd0);
      rd("rst cmp_lo", OFF_MTIMECMP_LO, 32'hFFFF_FFFF);
      rd("rst cmp_hi", OFF_MTIMECMP_HI, 32'hFFFF_FFFF);
      rd("rst ctrl", OFF_CTRL, 32'd0);
      rd("rst prescale", OFF_PRESCALE, 32'd0);
      rd("rst status", OFF_STATUS, 32'd0);
      rd("reserved", OFF_RSVD, 32'd0);
      intr("rst t_intr", 1'b0);
      idle(1);
      rd_at("rd_en low", ra(OFF_MTIMECMP_LO), 1'b0, 32'd0);
      rd_at("addr miss", BASE + 32'd40, 1'b1, 32'd0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
         if (g !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.nm, g, e.v);
         end
      end
   endtask

   task automatic test_cmp_intr();
      exp_t e; logic [31:0] g;
      do_reset();
      wreg(OFF_PRESCALE, 32'd0);
      wreg(OFF_MTIMECMP_HI, 32'd0);
      wreg(OFF_MTIMECMP_LO, 32'd5);
      wreg(OFF_CTRL, 32'd5);
      rd("cmp start mtime", OFF_MTIME_LO, 32'd0);
      idle(5);
      rd("cmp mtime at 5", OFF_MTIME_LO, 32'd5);
      rd("cmp pend at 5", OFF_STATUS, 32'd0);
      intr("cmp t_intr at 5", 1'b0);
      idle(1);
      rd("cmp mtime at 6", OFF_MTIME_LO, 32'd6);
      rd("cmp pend set", OFF_STATUS, 32'd1);
      intr("cmp t_intr lag", 1'b0);
      idle(1);
      intr("cmp t_intr set", 1'b1);
      rd("ctrl readback", OFF_CTRL, 32'd5);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
         if (g !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.nm, g, e.v);
         end
      end
   endtask

   task automatic test_prescale();
      exp_t e; logic [31:0] g;
      do_reset();
      wreg(OFF_PRESCALE, 32'd3);
      wreg(OFF_CTRL, 32'd1);
      rd("presc start", OFF_MTIME_LO, 32'd0);
      idle(40);
      rd("presc 40 cycles", OFF_MTIME_LO, 32'd10);
      rd("presc readback", OFF_PRESCALE, 32'd3);
      wreg(OFF_CTRL, 32'd0);
      idle(10);
      rd("idle holds", OFF_MTIME_LO, 32'd10);
      wreg(OFF_CTRL, 32'd1);
      idle(3);
      rd("restart cleared cnt", OFF_MTIME_LO, 32'd10);
      idle(1);
      rd("restart first tick", OFF_MTIME_LO, 32'd11);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
         if (g !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.nm, g, e.v);
         end
      end
   endtask

   task automatic test_periodic();
      exp_t e; logic [31:0] g;
      do_reset();
      wreg(OFF_PRESCALE, 32'd0);
      wreg(OFF_MTIMECMP_HI, 32'd0);
      wreg(OFF_MTIMECMP_LO, 32'd2);
      wreg(OFF_CTRL, 32'd3);
      for (int i = 0; i < 6; i++) begin
         rd("periodic mtime", OFF_MTIME_LO, 32'(i % 3));
         rd("periodic pend", OFF_STATUS, (i >= 3) ? 32'd1 : 32'd0);
         idle(1);
      end
      rd("periodic mtime_hi", OFF_MTIME_HI, 32'd0);
      wreg(OFF_STATUS, 32'd1);
      rd("w1c clears", OFF_STATUS, 32'd0);
      rd("after w1c mtime", OFF_MTIME_LO, 32'd1);
      idle(1);
      rd("pend at 2", OFF_STATUS, 32'd0);
      idle(1);
      rd("pend reset by reload", OFF_STATUS, 32'd1);
      idle(2);
      wreg(OFF_STATUS, 32'd1);
      rd("set beats clear", OFF_STATUS, 32'd1);
      rd("reload during w1c", OFF_MTIME_LO, 32'd0);
      wreg(OFF_STATUS, 32'd0);
      rd("w0 no clear", OFF_STATUS, 32'd1);
      wreg(OFF_MTIMECMP_LO, 32'd5);
      rd("cmp write clears", OFF_STATUS, 32'd0);
      intr("periodic ie off", 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
         if (g !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.nm, g, e.v);
         end
      end
   endtask

   task automatic test_carry();
      exp_t e; logic [31:0] g;
      do_reset();
      wreg(OFF_MTIME_LO, 32'hFFFF_FFFF);
      wreg(OFF_PRESCALE, 32'd0);
      wreg(OFF_CTRL, 32'd1);
      rd("carry pre lo", OFF_MTIME_LO, 32'hFFFF_FFFF);
      rd("carry pre hi", OFF_MTIME_HI, 32'd0);
      idle(1);
      rd("carry lo", OFF_MTIME_LO, 32'd0);
      rd("carry hi", OFF_MTIME_HI, 32'd1);
      wreg(OFF_MTIME_HI, 32'hFFFF_FFFF);
      rd("wr hi beats tick hi", OFF_MTIME_HI, 32'hFFFF_FFFF);
      rd("wr hi beats tick lo", OFF_MTIME_LO, 32'd0);
      wreg(OFF_MTIME_LO, 32'hFFFF_FFFF);
      rd("max lo", OFF_MTIME_LO, 32'hFFFF_FFFF);
      rd("max pend", OFF_STATUS, 32'd0);
      idle(1);
      rd("wrap lo", OFF_MTIME_LO, 32'd0);
      rd("wrap hi", OFF_MTIME_HI, 32'd0);
      rd("pend at equal", OFF_STATUS, 32'd1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
         if (g !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.nm, g, e.v);
         end
      end
   endtask

   task automatic test_ignored_writes();
      exp_t e; logic [31:0] g;
      do_reset();
      wr(ra(OFF_CTRL), 32'd7, 3'b000);
      wr(ra(OFF_CTRL), 32'd7, 3'b001);
      wr(ra(OFF_PRESCALE), 32'd9, 3'b100);
      wr(BASE + 32'd32, 32'h0000_1234, 3'b010);
      wr(BASE + 32'd48, 32'd7, 3'b010);
      wr(BASE - 32'd24, 32'd0, 3'b010);
      idle(2);
      rd("ign mtime_lo", OFF_MTIME_LO, 32'd0);
      rd("ign mtime_hi", OFF_MTIME_HI, 32'd0);
      rd("ign cmp_lo", OFF_MTIMECMP_LO, 32'hFFFF_FFFF);
      rd("ign cmp_hi", OFF_MTIMECMP_HI, 32'hFFFF_FFFF);
      rd("ign ctrl", OFF_CTRL, 32'd0);
      rd("ign prescale", OFF_PRESCALE, 32'd0);
      rd("ign status", OFF_STATUS, 32'd0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
         if (g !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.nm, g, e.v);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      exp_t e; logic [31:0] g;
      do_reset();
      wreg(OFF_PRESCALE, 32'd0);
      wreg(OFF_MTIMECMP_HI, 32'd0);
      wreg(OFF_MTIMECMP_LO, 32'd3);
      wreg(OFF_CTRL, 32'd5);
      idle(8);
      rd("mid pend", OFF_STATUS, 32'd1);
      rd("mid mtime", OFF_MTIME_LO, 32'd8);
      intr("mid t_intr", 1'b1);
      rst = 1'b0;
      #1;
      intr("async t_intr", 1'b0);
      rd("async mtime_lo", OFF_MTIME_LO, 32'd0);
      rd("async mtime_hi", OFF_MTIME_HI, 32'd0);
      rd("async cmp_lo", OFF_MTIMECMP_LO, 32'hFFFF_FFFF);
      rd("async cmp_hi", OFF_MTIMECMP_HI, 32'hFFFF_FFFF);
      rd("async ctrl", OFF_CTRL, 32'd0);
      rd("async prescale", OFF_PRESCALE, 32'd0);
      rd("async status", OFF_STATUS, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      idle(3);
      rd("post rst idle", OFF_MTIME_LO, 32'd0);
      intr("post rst t_intr", 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
         if (g !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.nm, g, e.v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_cmp_intr();
      test_prescale();
      test_periodic();
      test_carry();
      test_ignored_writes();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
